// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
// Holds the sequencer state encoding, trap cause codes and default handler/depth values.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT,
    ST_T_RDR,
    ST_E_OP,
    ST_E_RDR
  } state_t;

  localparam logic [4:0]  CAUSE_SYSCALL    = 5'b01000;
  localparam logic [4:0]  CAUSE_BREAK      = 5'b01001;
  localparam logic [4:0]  CAUSE_TEQ        = 5'b01101;
  localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_0004;
  localparam int          DEF_MAX_DEPTH    = 6;

endpackage

// File: rtl/exc_depth_ctr.sv
// Saturating up/down counter with full/empty flags.
// Tracks trap nesting depth and doubles as the optional statistics counter.
module exc_depth_ctr #(
  parameter int unsigned    W   = 3,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == MAX);
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/exc_seq.sv
// Exception sequencer between decode/PC and CP0: sequences trap commit and ERET, redirects the PC.
// Optional statistics counters (taken_cnt/drop_cnt) are enabled by defining EXC_SEQ_STATS_EN.
module exc_seq
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
  parameter int          MAX_DEPTH    = DEF_MAX_DEPTH,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req,
  input  logic [4:0]        trap_cause,
  input  logic [31:0]       trap_pc,
  input  logic              eret_req,
  input  logic              cp0_exc_valid,
  input  logic [31:0]       cp0_exc_addr,
  output logic              cp0_exception,
  output logic [4:0]        cp0_cause,
  output logic              cp0_must_exc,
  output logic              cp0_eret,
  output logic [31:0]       cp0_pc,
  output logic              stall,
  output logic              pc_redirect,
  output logic [31:0]       redirect_pc,
  output logic              trap_ack,
  output logic              trap_drop,
  output logic              eret_ack,
  output logic [2:0]        depth
`ifdef EXC_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cause;
  logic [31:0] r_pc;
  logic        w_latch;
  logic        w_inc;
  logic        w_dec;
  logic        w_full;
  logic        w_empty;

  exc_depth_ctr #(
    .W   (3),
    .MAX (3'(MAX_DEPTH))
  ) u_depth (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_cnt   (depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The PC is stored pre-incremented so CP0, which records cp0_pc-4, ends up with the trapping PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cause <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_cause <= trap_cause;
        r_pc    <= trap_pc + 32'd4;
      end
    end
  end

  assign cp0_cause = r_cause;
  assign cp0_pc    = r_pc;

  always_comb begin
    w_next        = r_state;
    w_latch       = 1'b0;
    w_inc         = 1'b0;
    w_dec         = 1'b0;
    stall         = (r_state != ST_IDLE);
    cp0_exception = 1'b0;
    cp0_must_exc  = 1'b0;
    cp0_eret      = 1'b0;
    pc_redirect   = 1'b0;
    redirect_pc   = '0;
    trap_ack      = 1'b0;
    trap_drop     = 1'b0;
    eret_ack      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // ERET wins over a simultaneous trap; the trap stays pending on its held request.
        if (eret_req) begin
          if (!w_empty) w_next = ST_E_OP;
          else          eret_ack = 1'b1;
        end else if (trap_req) begin
          w_latch = 1'b1;
          w_next  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cp0_exception = 1'b1;
        if (cp0_exc_valid && !w_full) begin
          w_next = ST_COMMIT;
        end else begin
          trap_ack  = 1'b1;
          trap_drop = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        cp0_must_exc = 1'b1;
        w_next       = ST_T_RDR;
      end
      ST_T_RDR: begin
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_ADDR;
        trap_ack    = 1'b1;
        w_inc       = 1'b1;
        w_next      = ST_IDLE;
      end
      ST_E_OP: begin
        cp0_eret = 1'b1;
        w_next   = ST_E_RDR;
      end
      ST_E_RDR: begin
        pc_redirect = 1'b1;
        redirect_pc = cp0_exc_addr + 32'd4;
        eret_ack    = 1'b1;
        w_dec       = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef EXC_SEQ_STATS_EN
  logic w_takenFull;
  logic w_takenEmpty;
  logic w_dropFull;
  logic w_dropEmpty;

  exc_depth_ctr #(.W(CNT_W)) u_takenCnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_dec   (1'b0),
    .o_cnt   (taken_cnt),
    .o_full  (w_takenFull),
    .o_empty (w_takenEmpty)
  );

  exc_depth_ctr #(.W(CNT_W)) u_dropCnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (trap_drop),
    .i_dec   (1'b0),
    .o_cnt   (drop_cnt),
    .o_full  (w_dropFull),
    .o_empty (w_dropEmpty)
  );
`else
  // Statistics counters are not built.
`endif

endmodule

// File: doc/exc_seq.md
Name: exc_seq

Overview:
- Exception sequencer sitting between the CPU decode/PC stage and the CP0 coprocessor.
- Accepts trap requests (syscall/break/teq) and ERET requests from decode.
- Drives the CP0 side of the trap protocol: exception, cause, mustException, eret and pc.
- Consumes CP0 exceptionValid and exc_addr, stalls the pipeline while sequencing, and issues a one-cycle PC redirect to the handler or the return address.
- Tracks nesting depth so the CP0 status shift stack (5 bits per level) never overflows.

Parameters:
- HANDLER_ADDR, 32'h00000004: handler entry PC driven on trap redirect.
- MAX_DEPTH, 6: maximum nested trap levels (32-bit status / 5 bits per level).
- CNT_W, 16: width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- trap_req  in  1  trap request from decode; held high until trap_ack.
- trap_cause  in  5  cause code: 5'b01000 syscall, 5'b01001 break, 5'b01101 teq.
- trap_pc  in  32  PC of the trapping instruction.
- eret_req  in  1  ERET request; held high until eret_ack.
- cp0_exc_valid  in  1  CP0 exceptionValid, combinational from cp0_exception/cp0_cause.
- cp0_exc_addr  in  32  CP0 EPC (register 14).
- cp0_exception  out  1  exception probe to CP0.
- cp0_cause  out  5  cause to CP0.
- cp0_must_exc  out  1  commit strobe to CP0 (mustException).
- cp0_eret  out  1  ERET strobe to CP0.
- cp0_pc  out  32  PC handed to CP0; CP0 stores cp0_pc-4.
- stall  out  1  freeze fetch/decode.
- pc_redirect  out  1  one-cycle redirect strobe.
- redirect_pc  out  32  redirect target, valid when pc_redirect=1.
- trap_ack  out  1  one-cycle, trap request consumed (taken or dropped).
- trap_drop  out  1  one-cycle, coincident with trap_ack when the trap was rejected.
- eret_ack  out  1  one-cycle, ERET request consumed.
- depth  out  3  current nesting level.

Behaviour:
- Reset (rst=0, async): state IDLE, depth=0, cause/pc latches=0, all outputs 0.
- States: IDLE, CHECK, COMMIT, T_RDR, E_OP, E_RDR. stall=1 in every state except IDLE.
- IDLE:
  - eret_req has priority over trap_req; the trap stays pending.
  - eret_req with depth>0 -> E_OP.
  - eret_req with depth=0 -> eret_ack=1 combinationally in IDLE, stay IDLE, no CP0 strobe, no redirect.
  - trap_req alone -> latch trap_cause and trap_pc -> CHECK.
- CHECK:
  - Drive cp0_exception=1 and cp0_cause=latched cause.
  - If cp0_exc_valid=1 and depth<MAX_DEPTH -> COMMIT.
  - Otherwise pulse trap_ack=1 and trap_drop=1 this cycle -> IDLE.
- COMMIT: cp0_must_exc=1, cp0_pc=latched_pc+4 (CP0 therefore records latched_pc) -> T_RDR.
- T_RDR: pc_redirect=1, redirect_pc=HANDLER_ADDR, trap_ack=1; depth+1 at the clock edge -> IDLE.
- E_OP: cp0_eret=1 -> E_RDR.
- E_RDR: pc_redirect=1, redirect_pc=cp0_exc_addr+4, eret_ack=1; depth-1 at the clock edge -> IDLE.
- Latency:
  - Taken trap: redirect 3 cycles after trap_req is sampled in IDLE.
  - Dropped trap: ack 1 cycle after sampling.
  - ERET: redirect 2 cycles after sampling.
- Outside the strobes named above, cp0_* outputs are 0. cp0_cause and cp0_pc hold their latched values.
- Requests arriving while not in IDLE are ignored until IDLE. Requesters hold their request lines.
- depth saturates: it never exceeds MAX_DEPTH and never goes below 0.
- Reset mid-sequence aborts immediately with no strobe completed. CP0 resets on the same reset net.

Optional Feature:
- EXC_SEQ_STATS_EN defined adds outputs taken_cnt[CNT_W] and drop_cnt[CNT_W]:
  - taken_cnt increments in T_RDR; drop_cnt increments on trap_drop.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package exc_pkg: state enum; cause constants CAUSE_SYSCALL=5'b01000, CAUSE_BREAK=5'b01001, CAUSE_TEQ=5'b01101; default HANDLER_ADDR.
- One natural sub-module: exc_depth_ctr (saturating up/down counter with full/empty flags), also used for the stats counters.

Test Plan:
- Syscall taken: cp0_exc_valid=1, trap_pc=32'h00400010, cause 5'b01000 -> CHECK, COMMIT (cp0_pc=32'h00400014), T_RDR redirect_pc=32'h00000004; trap_ack at cycle 3; depth=1.
- Masked break: cp0_exc_valid=0 -> trap_ack=trap_drop=1 one cycle after request; no cp0_must_exc; depth unchanged.
- ERET after a trap: cp0_exc_addr=32'h00400010 -> cp0_eret pulse, then redirect_pc=32'h00400014, eret_ack; depth 1->0.
- ERET at depth 0 -> eret_ack only; no cp0_eret, no pc_redirect.
- Nesting: 7 consecutive taken teq traps -> first 6 redirect, depth=6, 7th dropped; simultaneous eret_req+trap_req in IDLE -> ERET served first, trap served after.
- Reset asserted in COMMIT -> all outputs 0 asynchronously, depth=0, IDLE after release.
